// File: rtl/rx_frame_ctrl.sv
// Receive-side frame controller: captures one frame per Receiver handshake,
// buffers good bytes in a show-ahead FIFO, and tracks framing errors and overrun.
module rx_frame_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [7:0]                    RX_DATA,
  input  logic                          RX_READY,
  input  logic                          RX_ERROR,
  output logic                          DATA_ACK,
  input  logic                          RD_EN,
  output logic [7:0]                    DOUT,
  output logic                          DATA_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERRUN,
  output logic [ERR_CNT_W-1:0]          ERR_COUNT,
  input  logic                          CLR_STATUS,
  output logic                          state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]           mem_q [FIFO_DEPTH];

  logic capture, pop, room, push, drop, err_inc;

  // Handshakes: a frame is taken at the first edge RX_READY=1 is seen in IDLE,
  // and DATA_ACK holds until RX_READY=0 is seen; a byte leaves the FIFO at an
  // edge where RD_EN=1 and DATA_VALID=1 (RD_EN while empty is ignored).
  always_comb begin
    capture = (state_q == IDLE) && RX_READY;
    pop     = RD_EN && (count_q != '0);
    room    = (count_q < CW'(FIFO_DEPTH)) || pop;
    push    = capture && !RX_ERROR && room;
    drop    = capture && !RX_ERROR && !room;
    err_inc = capture && RX_ERROR;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (RX_READY) state_d = ACK;
      ACK:     if (!RX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A clear wins over any event arriving in the same cycle.
    if (CLR_STATUS) begin
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (drop) overrun_d = 1'b1;
      if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= RX_DATA;
  end

  assign DATA_ACK   = (state_q == ACK);
  assign DOUT       = mem_q[rd_ptr_q];
  assign DATA_VALID = (count_q != '0);
  assign FIFO_COUNT = count_q;
  assign OVERRUN    = overrun_q;
  assign ERR_COUNT  = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed scenarios plus randomized frames, checked
// against a queue-based model of the FIFO and status counters.
module tb_rx_frame_ctrl;

  localparam int DEPTH   = 4;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             rx_error;
  logic             data_ack;
  logic             rd_en;
  logic [7:0]       dout;
  logic             data_valid;
  logic [2:0]       fifo_count;
  logic             overrun;
  logic [ERR_W-1:0] err_count;
  logic             clr_status;
  logic             state_dbg;

  rx_frame_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .RX_DATA    (rx_data),
    .RX_READY   (rx_ready),
    .RX_ERROR   (rx_error),
    .DATA_ACK   (data_ack),
    .RD_EN      (rd_en),
    .DOUT       (dout),
    .DATA_VALID (data_valid),
    .FIFO_COUNT (fifo_count),
    .OVERRUN    (overrun),
    .ERR_COUNT  (err_count),
    .CLR_STATUS (clr_status),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [7:0] exp_q[$];
  int         m_err;
  bit         m_ovr;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_err = 0;
    m_ovr = 0;
  endtask

  // One clock edge of the model: optional pop, optional frame, optional clear.
  task automatic model_edge(input bit cap, input logic [7:0] d, input bit err,
                            input bit rd, input bit clr);
    bit pop_ok;
    bit has_room;
    pop_ok   = rd && (exp_q.size() > 0);
    has_room = (exp_q.size() < DEPTH) || pop_ok;
    if (pop_ok) void'(exp_q.pop_front());
    if (cap && !err && has_room) exp_q.push_back(d);
    if (clr) begin
      m_err = 0;
      m_ovr = 0;
    end else if (cap) begin
      if (err) m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
      else if (!has_room) m_ovr = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(data_valid), 32'(exp_q.size() != 0));
    check({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    check({tag, "_errcnt"}, 32'(err_count), 32'(m_err));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    if (exp_q.size() != 0) check({tag, "_dout"}, 32'(dout), 32'(exp_q[0]));
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic send_frame(input logic [7:0] d, input bit err, input bit rd,
                            input bit clr, input int hold);
    rx_data    = d;
    rx_error   = err;
    rx_ready   = 1'b1;
    rd_en      = rd;
    clr_status = clr;
    @(posedge clk);
    model_edge(1'b1, d, err, rd, clr);
    @(negedge clk);
    rd_en      = 1'b0;
    clr_status = 1'b0;
    check("ack_high", 32'(data_ack), 32'd1);
    check_outputs("capture");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ack_hold", 32'(data_ack), 32'd1);
    end
    rx_ready = 1'b0;
    rx_error = 1'b0;
    @(negedge clk);
    check("ack_low", 32'(data_ack), 32'd0);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rd_en = 1'b0;
    check_outputs("pop");
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clr_status = 1'b0;
    check_outputs("clear");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_ready   = 1'b0;
    rx_error   = 1'b0;
    rd_en      = 1'b0;
    clr_status = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(data_ack), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: one good frame
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 2);
    check("t1_dout", 32'(dout), 32'h55);
    check("t1_count", 32'(fifo_count), 32'd1);

    // 2: framing error, acked but not stored
    send_frame(8'hD5, 1'b1, 1'b0, 1'b0, 1);
    check("t2_count", 32'(fifo_count), 32'd1);
    check("t2_errcnt", 32'(err_count), 32'd1);
    do_pop();

    // 3: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 0);
    check("t3_count", 32'(fifo_count), 32'd4);
    check("t3_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) do_pop();
    check("t3_valid", 32'(data_valid), 32'd0);
    do_pop();

    // 4: full FIFO, capture and pop on the same edge
    clr_pulse();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h10, 1'b0, 1'b1, 1'b0, 0);
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_ovr", 32'(overrun), 32'd0);
    check("t4_head", 32'(dout), 32'h02);
    for (int i = 0; i < 3; i++) do_pop();
    check("t4_last", 32'(dout), 32'h10);
    do_pop();

    // 5: error counter saturation and clear priority
    for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 0);
    check("t5_sat", 32'(err_count), 32'hFF);
    check("t5_ovr_set", 32'(overrun), 32'd1);
    send_frame(8'hEE, 1'b1, 1'b0, 1'b1, 0);
    check("t5_clr_err", 32'(err_count), 32'd0);
    check("t5_clr_ovr", 32'(overrun), 32'd0);

    // 6: reset while acknowledging with two bytes buffered
    for (int i = 0; i < DEPTH && exp_q.size() > 2; i++) do_pop();
    rx_data  = 8'hA7;
    rx_error = 1'b0;
    rx_ready = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 8'hA7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_pre_ack", 32'(data_ack), 32'd1);
    check("t6_pre_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_ack", 32'(data_ack), 32'd0);
    check_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 8'hA7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_reack", 32'(data_ack), 32'd1);
    check("t6_count", 32'(fifo_count), 32'd1);
    check_outputs("t6_recap");
    @(negedge clk);
    check("t6_once", 32'(fifo_count), 32'd1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t6_ack_low", 32'(data_ack), 32'd0);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) do_pop();
      else send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                      int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
